uart_rx_packet_fifo: RTL and testbench

- Sits directly downstream of the UART receiver; consumes its byte strobe and end-of-packet pulse.
- Frames the byte stream into packets with an explicit last-byte tag and buffers them in a FIFO.
- Presents packets to the bitstream/control logic over a valid/ready interface.
- Holds back one byte so the end-of-packet gap, which is reported after the final byte, can tag that byte.

---
 rtl/uart_rx_packet_fifo.sv | 146 ++++++++++++++
 tb/tb_uart_rx_packet_fifo.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_packet_fifo.sv
// Purpose: frames UART receiver bytes into last-tagged packets and buffers them in a FIFO (UART_RX_PKT_CHECKSUM_EN adds out_err).
// Latency: a byte reaches out_* the cycle after the next strobe/EOP, or the cycle after staging when forced at MAX_PKT_LEN.
// Backpressure: out_valid/out_ready; a push into a full FIFO without a same-cycle pop is dropped and sets sticky overflow.
module uart_rx_packet_fifo #(
  parameter int DEPTH       = 16,
  parameter int MAX_PKT_LEN = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               rxd_data,
  input  logic                     rxd_data_ready,
  input  logic                     rxd_endofpacket,
  output logic [7:0]               out_data,
  output logic                     out_last,
`ifdef UART_RX_PKT_CHECKSUM_EN
  output logic                     out_err,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  input  logic                     clear_overflow
);

`ifdef UART_RX_PKT_CHECKSUM_EN
  localparam int FW = 10;  // {err, last, data}
`else
  localparam int FW = 9;   // {last, data}
`endif
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [16:0]   MAX_LEN  = 17'(MAX_PKT_LEN);

  // Staging register and packet framing state
  logic [7:0]  stg_data_q, stg_data_d;
  logic        stg_valid_q, stg_valid_d;
  logic [15:0] pkt_len_q, pkt_len_d;   // bytes already pushed in the current packet
  logic [16:0] stg_len;                // position of the staged byte within its packet
  logic        overflow_q, overflow_d;
  logic        force_last, push, push_last, push_ok, pop;
  logic [FW-1:0] push_dat;
`ifdef UART_RX_PKT_CHECKSUM_EN
  logic [7:0]  sum_q, sum_d, sum_nxt;
`endif

  // FIFO storage and pointers
  logic [FW-1:0] mem_q [DEPTH];
  logic [FW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;

  assign stg_len = {1'b0, pkt_len_q} + 17'd1;

  // Decide whether the staged byte leaves this cycle, and how it is tagged
  always_comb begin
    force_last  = stg_valid_q && (stg_len == MAX_LEN);
    push        = stg_valid_q && (rxd_data_ready || rxd_endofpacket || force_last);
    push_last   = rxd_endofpacket || force_last;
    stg_data_d  = stg_data_q;
    stg_valid_d = stg_valid_q;
    pkt_len_d   = pkt_len_q;
`ifdef UART_RX_PKT_CHECKSUM_EN
    sum_nxt  = sum_q + stg_data_q;
    sum_d    = sum_q;
    push_dat = {push_last && (sum_nxt != 8'h00), push_last, stg_data_q};
`else
    push_dat = {push_last, stg_data_q};
`endif
    if (push) begin
      stg_valid_d = 1'b0;
      // Dropped pushes still advance the counter so framing stays aligned
      pkt_len_d   = push_last ? 16'd0 : pkt_len_q + 16'd1;
`ifdef UART_RX_PKT_CHECKSUM_EN
      sum_d       = push_last ? 8'h00 : sum_nxt;
`endif
    end
    // A new byte always lands in the stage; any EOP already applied to the old one
    if (rxd_data_ready) begin
      stg_data_d  = rxd_data;
      stg_valid_d = 1'b1;
    end
  end

  // FIFO next-state: accept a push when not full or when a pop frees a slot
  always_comb begin
    pop      = (cnt_q != '0) && out_ready;
    push_ok  = push && ((cnt_q != FULL_CNT) || pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
    // A drop in the same cycle as a clear leaves overflow set
    overflow_d = (push && !push_ok) ? 1'b1 : (clear_overflow ? 1'b0 : overflow_q);
  end

  // State registers; reset discards the stage, the FIFO contents and any partial packet
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_data_q  <= '0;
      stg_valid_q <= 1'b0;
      pkt_len_q   <= '0;
      overflow_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
`ifdef UART_RX_PKT_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      stg_data_q  <= stg_data_d;
      stg_valid_q <= stg_valid_d;
      pkt_len_q   <= pkt_len_d;
      overflow_q  <= overflow_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
`ifdef UART_RX_PKT_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign out_data   = mem_q[rd_ptr_q][7:0];
  assign out_last   = mem_q[rd_ptr_q][8];
`ifdef UART_RX_PKT_CHECKSUM_EN
  assign out_err    = mem_q[rd_ptr_q][9];
`endif
  assign out_valid  = (cnt_q != '0);
  assign fifo_level = cnt_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_rx_packet_fifo.sv
// Purpose: randomized and directed bench for uart_rx_packet_fifo against a packet-level queue model.
// Latency: every cycle is compared right after the clock edge.
// Backpressure: out_ready is driven from the stimulus; drops are predicted from model occupancy.
module tb_uart_rx_packet_fifo;
  localparam int DEPTH = 4;
  localparam int MAXL  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rxd_data = '0;
  logic       rxd_data_ready = 1'b0;
  logic       rxd_endofpacket = 1'b0;
  logic [7:0] out_data;
  logic       out_last;
`ifdef UART_RX_PKT_CHECKSUM_EN
  logic       out_err;
`endif
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [$clog2(DEPTH):0] fifo_level;
  logic       overflow;
  logic       clear_overflow = 1'b0;

  always #5 clk = ~clk;

  uart_rx_packet_fifo #(.DEPTH(DEPTH), .MAX_PKT_LEN(MAXL)) dut (
    .clk(clk), .rst_n(rst_n),
    .rxd_data(rxd_data), .rxd_data_ready(rxd_data_ready), .rxd_endofpacket(rxd_endofpacket),
    .out_data(out_data), .out_last(out_last),
`ifdef UART_RX_PKT_CHECKSUM_EN
    .out_err(out_err),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .fifo_level(fifo_level),
    .overflow(overflow), .clear_overflow(clear_overflow)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: byte stream -> packet entries {err,last,data} in a bounded queue
  logic [9:0] mq[$];
  logic [9:0] got_q[$];
  bit         m_pend;
  logic [7:0] m_pb;
  int         m_cnt;
  bit         m_ovf;
  int         m_sum;

  task automatic model_reset();
    mq.delete();
    m_pend = 0; m_pb = '0; m_cnt = 0; m_ovf = 0; m_sum = 0;
  endtask

  task automatic model_step(input bit s, input logic [7:0] b, input bit e, input bit r, input bit c);
    bit pop, emit, last;
    logic [9:0] ent;
    pop  = (mq.size() != 0) && r;
    emit = m_pend && (s || e || (m_cnt + 1 == MAXL));
    last = e || (m_cnt + 1 == MAXL);
    ent  = '0;
    if (c) m_ovf = 0;
    if (emit) begin
      m_sum = (m_sum + int'(m_pb)) % 256;
`ifdef UART_RX_PKT_CHECKSUM_EN
      ent = {last && (m_sum != 0), last, m_pb};
`else
      ent = {1'b0, last, m_pb};
`endif
      if (last) begin m_cnt = 0; m_sum = 0; end
      else m_cnt++;
    end
    if (pop) void'(mq.pop_front());
    if (emit) begin
      if (mq.size() < DEPTH) mq.push_back(ent);
      else m_ovf = 1;
    end
    if (s) begin m_pend = 1; m_pb = b; end
    else if (emit) m_pend = 0;
  endtask

  task automatic check_all();
    chk("out_valid", out_valid, mq.size() != 0);
    chk("fifo_level", fifo_level, mq.size());
    chk("overflow", overflow, m_ovf);
    if (mq.size() != 0) begin
      chk("out_data", out_data, mq[0][7:0]);
      chk("out_last", out_last, mq[0][8]);
`ifdef UART_RX_PKT_CHECKSUM_EN
      chk("out_err", out_err, mq[0][9]);
`endif
    end
  endtask

  // One clock: drive, record the DUT's handshake, step the model, compare after the edge
  task automatic cyc(input bit s, input logic [7:0] b, input bit e, input bit r, input bit c);
    logic eb;
    rxd_data_ready = s; rxd_data = b; rxd_endofpacket = e; out_ready = r; clear_overflow = c;
    #1;
`ifdef UART_RX_PKT_CHECKSUM_EN
    eb = out_err;
`else
    eb = 1'b0;
`endif
    if (out_valid && out_ready) got_q.push_back({eb, out_last, out_data});
    model_step(s, b, e, r, c);
    @(posedge clk);
    #1;
    rxd_data_ready = 1'b0; rxd_endofpacket = 1'b0; clear_overflow = 1'b0;
    check_all();
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) cyc(0, 8'h00, 0, r, 0);
  endtask

  task automatic send(input logic [7:0] b, input bit r);
    cyc(1, b, 0, r, 0);
    idle(2, r);
  endtask

  task automatic eop(input bit r);
    cyc(0, 8'h00, 1, r, 0);
    idle(2, r);
  endtask

  task automatic cmp_got(input string tag, input logic [9:0] e[$]);
    chk({tag, "_count"}, got_q.size(), e.size());
    for (int i = 0; i < e.size() && i < got_q.size(); i++)
      chk($sformatf("%s_%0d", tag, i), got_q[i], e[i]);
    got_q.delete();
  endtask

  initial begin
    logic [9:0] e[$];
    model_reset();
    #12;
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_fifo_level", fifo_level, 0);
    chk("rst_overflow", overflow, 0);
`ifdef UART_RX_PKT_CHECKSUM_EN
    chk("rst_out_err", out_err, 0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic framing
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); eop(0);
    chk("t1_level_peak", fifo_level, 3);
    idle(5, 1);
    e = {10'h011, 10'h022, 10'h133};
    cmp_got("t1", e);

    // Lone EOP is ignored, single-byte packet
    eop(1); send(8'hA5, 1); eop(1); idle(3, 1);
    e = {10'h1A5};
    cmp_got("t2", e);

    // Length limit forces the last tag without waiting for the next byte
    send(8'h01, 1); send(8'h02, 1); send(8'h03, 1);
    cyc(1, 8'h04, 0, 1, 0);
    cyc(0, 8'h00, 0, 1, 0);
    chk("t3_force_data", out_data, 8'h04);
    chk("t3_force_last", out_last, 1);
    idle(2, 1);
    send(8'h05, 1); send(8'h06, 1); eop(1); idle(3, 1);
    e = {10'h001, 10'h002, 10'h003, 10'h104, 10'h005, 10'h106};
    cmp_got("t3", e);

    // Overflow with a stalled consumer, clear, drain
    for (int i = 1; i <= 6; i++) send(8'(i), 0);
    eop(0);
    chk("t4_level", fifo_level, 4);
    chk("t4_overflow", overflow, 1);
    cyc(0, 8'h00, 0, 0, 1);
    chk("t4_cleared", overflow, 0);
    idle(6, 1);
    e = {10'h001, 10'h002, 10'h003, 10'h104};
    cmp_got("t4", e);

    // Full FIFO, push and pop in the same cycle
    send(8'h21, 0); send(8'h22, 0); send(8'h23, 0); send(8'h24, 0);
    send(8'h31, 0);
    chk("t5_full", fifo_level, 4);
    cyc(1, 8'h32, 0, 1, 0);
    chk("t5_pushpop_level", fifo_level, 4);
    chk("t5_pushpop_ovf", overflow, 0);
    got_q.delete();

    // Reset mid-packet takes effect immediately; nothing partial follows release
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_level", fifo_level, 0);
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    eop(1); idle(2, 1);
    chk("t5_post_rst_level", fifo_level, 0);
    e = {};
    cmp_got("t5", e);

`ifdef UART_RX_PKT_CHECKSUM_EN
    send(8'h10, 1); send(8'h20, 1); send(8'hD0, 1); eop(1);
    send(8'h10, 1); send(8'h20, 1); send(8'hD1, 1); eop(1);
    idle(4, 1);
    e = {10'h010, 10'h020, 10'h1D0, 10'h010, 10'h020, 10'h3D1};
    cmp_got("t6", e);
`endif

    // Randomized traffic
    for (int i = 0; i < 4000; i++)
      cyc($urandom_range(3) == 0, 8'($urandom), $urandom_range(5) == 0,
          $urandom_range(2) != 0, $urandom_range(49) == 0);
    idle(10, 1);
    chk("rand_drained", fifo_level, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
